// File: rtl/mux41_case_if.sv
// mux41_case_if -- signal bundle for the 4:1 mux with select-change tracking.
//   s0, s1      : 2-bit select, s1 is the MSB
//   w0..w3      : single-bit data inputs
//   f           : combinational mux output
//   f_q         : f registered on clk
//   sel_chg     : one-cycle pulse when the select differs from the previous edge
//   chg_cnt     : saturating (255) count of select changes
// master drives select/data and observes the outputs; slave is the mux side.
interface mux41_case_if;
   logic       s0;
   logic       s1;
   logic       w0;
   logic       w1;
   logic       w2;
   logic       w3;
   logic       f;
   logic       f_q;
   logic       sel_chg;
   logic [7:0] chg_cnt;

   modport master (
      output s0, s1, w0, w1, w2, w3,
      input  f, f_q, sel_chg, chg_cnt
   );

   modport slave (
      input  s0, s1, w0, w1, w2, w3,
      output f, f_q, sel_chg, chg_cnt
   );
endinterface

// File: rtl/mux41_case.sv
// mux41_case -- 4:1 single-bit mux with a registered copy of the output and
// select-change detection.
//   clk  : rising-edge clock for all registered state
//   rst  : asynchronous active-high reset, clears all registers at once
//   bus  : mux41_case_if.slave (select, data, f, f_q, sel_chg, chg_cnt)
// f is purely combinational and keeps tracking the inputs during reset.
module mux41_case (
   input  logic              clk,
   input  logic              rst,
   mux41_case_if.slave       bus
);

   localparam logic [7:0] CNT_MAX = 8'd255;

   logic [1:0] sel;
   logic       f;

   logic       f_q;
   logic       f_q_d;
   logic [1:0] sel_q;
   logic [1:0] sel_d;
   logic       sel_chg_q;
   logic       sel_chg_d;
   logic [7:0] chg_cnt_q;
   logic [7:0] chg_cnt_d;
   logic       chg_det;

   assign sel = {bus.s1, bus.s0};

   // An unknown select falls into the default branch and forces f low
   // rather than propagating an arbitrary data bit.
   always_comb begin
      f = 1'b0;
      case (sel)
         2'b00:   f = bus.w0;
         2'b01:   f = bus.w1;
         2'b10:   f = bus.w2;
         2'b11:   f = bus.w3;
         default: f = 1'b0;
      endcase
   end

   always_comb begin
      chg_det   = (sel != sel_q);
      f_q_d     = f;
      sel_d     = sel;
      sel_chg_d = chg_det;
      chg_cnt_d = chg_cnt_q;
      if (chg_det && (chg_cnt_q != CNT_MAX)) begin
         chg_cnt_d = chg_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f_q       <= 1'b0;
         sel_q     <= 2'b00;
         sel_chg_q <= 1'b0;
         chg_cnt_q <= 8'd0;
      end else begin
         f_q       <= f_q_d;
         sel_q     <= sel_d;
         sel_chg_q <= sel_chg_d;
         chg_cnt_q <= chg_cnt_d;
      end
   end

   assign bus.f       = f;
   assign bus.f_q     = f_q;
   assign bus.sel_chg = sel_chg_q;
   assign bus.chg_cnt = chg_cnt_q;

endmodule

// File: tb/tb_mux41_case.sv
// tb_mux41_case -- directed-vector bench for mux41_case.
module tb_mux41_case;

   logic clk;
   logic rst;
   int   n_total;
   int   n_bad;

   mux41_case_if bus_if ();

   mux41_case dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // w bit i drives data input wi
   task automatic set_in(input logic [1:0] sel, input logic [3:0] w);
      bus_if.s1 = sel[1];
      bus_if.s0 = sel[0];
      bus_if.w0 = w[0];
      bus_if.w1 = w[1];
      bus_if.w2 = w[2];
      bus_if.w3 = w[3];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      check_val("rst_f_q", {7'd0, bus_if.f_q}, 8'd0);
      check_val("rst_sel_chg", {7'd0, bus_if.sel_chg}, 8'd0);
      check_val("rst_chg_cnt", bus_if.chg_cnt, 8'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   // Each row: data word and the expected f for select 00,01,10,11.
   typedef struct {
      logic [3:0] w;
      logic [3:0] f_exp;
   } sweep_vec_t;

   sweep_vec_t sweeps [5] = '{
      '{w: 4'b0000, f_exp: 4'b0000},
      '{w: 4'b0001, f_exp: 4'b0001},
      '{w: 4'b0010, f_exp: 4'b0010},
      '{w: 4'b0100, f_exp: 4'b0100},
      '{w: 4'b1000, f_exp: 4'b1000}
   };

   initial begin
      logic       prev_f;
      logic [7:0] cnt_before;
      n_total = 0;
      n_bad   = 0;
      rst     = 1'b0;
      set_in(2'b00, 4'b0000);

      // Reset, with f tracking data while rst is held
      #2 rst = 1'b1;
      set_in(2'b00, 4'b0001);
      #1;
      check_val("rst_f_q0", {7'd0, bus_if.f_q}, 8'd0);
      check_val("rst_chg_cnt0", bus_if.chg_cnt, 8'd0);
      check_val("rst_sel_chg0", {7'd0, bus_if.sel_chg}, 8'd0);
      check_val("f_in_rst", {7'd0, bus_if.f}, 8'd1);
      set_in(2'b01, 4'b0001);
      #1;
      check_val("f_in_rst_b", {7'd0, bus_if.f}, 8'd0);
      @(negedge clk);
      rst = 1'b0;
      // First edge after reset compares 01 against the cleared 00
      tick();
      check_val("first_edge_chg", {7'd0, bus_if.sel_chg}, 8'd1);
      check_val("first_edge_cnt", bus_if.chg_cnt, 8'd1);

      // Full select sweeps, combinational f and one-cycle-late f_q
      do_reset();
      for (int v = 0; v < 5; v++) begin
         for (int s = 0; s < 4; s++) begin
            logic [3:0] fe;
            fe = sweeps[v].f_exp;
            set_in(s[1:0], sweeps[v].w);
            #1;
            check_val($sformatf("sweep_f_w%b_s%0d", sweeps[v].w, s), {7'd0, bus_if.f}, {7'd0, fe[s]});
            tick();
            check_val($sformatf("sweep_fq_w%b_s%0d", sweeps[v].w, s), {7'd0, bus_if.f_q}, {7'd0, fe[s]});
         end
      end

      // Data-only change: no select change detected
      set_in(2'b10, 4'b0000);
      tick();
      cnt_before = bus_if.chg_cnt;
      set_in(2'b10, 4'b0100);
      tick();
      check_val("data_only_chg", {7'd0, bus_if.sel_chg}, 8'd0);
      check_val("data_only_cnt", bus_if.chg_cnt, cnt_before);
      check_val("data_only_fq", {7'd0, bus_if.f_q}, 8'd1);

      // Select and data changing together
      set_in(2'b01, 4'b0010);
      tick();
      check_val("both_chg", {7'd0, bus_if.sel_chg}, 8'd1);
      check_val("both_cnt", bus_if.chg_cnt, cnt_before + 8'd1);
      check_val("both_fq", {7'd0, bus_if.f_q}, 8'd1);

      // Hold 00 three clocks, then 11
      do_reset();
      set_in(2'b00, 4'b1000);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val($sformatf("hold00_chg_%0d", i), {7'd0, bus_if.sel_chg}, 8'd0);
         check_val($sformatf("hold00_cnt_%0d", i), bus_if.chg_cnt, 8'd0);
      end
      set_in(2'b11, 4'b1000);
      #1;
      check_val("to11_f", {7'd0, bus_if.f}, 8'd1);
      check_val("to11_fq_pre", {7'd0, bus_if.f_q}, 8'd0);
      tick();
      check_val("to11_chg", {7'd0, bus_if.sel_chg}, 8'd1);
      check_val("to11_cnt", bus_if.chg_cnt, 8'd1);
      check_val("to11_fq", {7'd0, bus_if.f_q}, 8'd1);
      tick();
      check_val("to11_chg_off", {7'd0, bus_if.sel_chg}, 8'd0);
      check_val("to11_cnt_hold", bus_if.chg_cnt, 8'd1);

      // Toggle every clock for 300 clocks: saturates at 255
      do_reset();
      for (int i = 1; i <= 300; i++) begin
         set_in((i % 2 == 1) ? 2'b11 : 2'b00, 4'b1000);
         tick();
         if (i == 254) check_val("sat_254", bus_if.chg_cnt, 8'd254);
         if (i == 255) check_val("sat_255", bus_if.chg_cnt, 8'd255);
         if (i == 256) check_val("sat_256", bus_if.chg_cnt, 8'd255);
      end
      check_val("sat_300", bus_if.chg_cnt, 8'd255);
      check_val("sat_300_chg", {7'd0, bus_if.sel_chg}, 8'd1);
      set_in(2'b11, 4'b1000);
      tick();
      check_val("sat_301", bus_if.chg_cnt, 8'd255);
      prev_f = bus_if.f_q;
      check_val("pre_rst_fq", {7'd0, prev_f}, 8'd1);
      #2 rst = 1'b1;
      #1;
      check_val("midrst_cnt", bus_if.chg_cnt, 8'd0);
      check_val("midrst_fq", {7'd0, bus_if.f_q}, 8'd0);
      check_val("midrst_chg", {7'd0, bus_if.sel_chg}, 8'd0);
      check_val("midrst_f", {7'd0, bus_if.f}, 8'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;

      // Unknown s0: w0/w1 low so f is 0 whichever way s0 resolves
      set_in(2'b00, 4'b1100);
      bus_if.s0 = 1'bx;
      #1;
      check_val("s0_x_f", {7'd0, bus_if.f}, 8'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
